// File: rtl/top_sr.sv
// top_sr: serial shift-register configuration master with readback FIFO (TOP_SR_FIFO_OVERFLOW_EN adds sticky fifo_overflow)
module top_sr #(
    parameter int WIDTH           = 50,
    parameter int CNT_WIDTH       = 8,
    parameter int DIV_WIDTH       = 6,
    parameter int COUNT_WIDTH     = 64,
    parameter int VALID_WIDTH     = 32,
    parameter int NUM_WIDTH       = 4,
    parameter int FIFO_WIDTH      = 36,
    parameter int SHIFT_DIRECTION = 1,
    parameter int READ_TRIG_SRC   = 0,
    parameter int READ_DELAY      = 0
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr_en,
    input  logic [15:0]           din,
    input  logic                  data_in,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  fifo_rd_en,
    output logic                  clk_sr,
    output logic                  data_out,
    output logic                  load_sr,
    output logic                  clk,
    output logic                  fifo_empty,
    output logic [FIFO_WIDTH-1:0] fifo_q
`ifdef TOP_SR_FIFO_OVERFLOW_EN
    ,
    output logic                  fifo_overflow
`endif
);
    localparam int N  = WIDTH + READ_DELAY;
    localparam int VW = $clog2(VALID_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] MASK = {COUNT_WIDTH{1'b1}} >> (COUNT_WIDTH - WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
    state_t state;

    logic [COUNT_WIDTH-1:0] staging, sr;
    logic [DIV_WIDTH-1:0]   dcnt;
    logic [CNT_WIDTH-1:0]   bcnt, scnt;
    logic [VW-1:0]          wbit;
    logic [VALID_WIDTH-2:0] acc;
    logic [VALID_WIDTH-1:0] acc_n;
    logic [NUM_WIDTH-1:0]   index;
    logic [FIFO_WIDTH-1:0]  pend_data;
    logic [FIFO_WIDTH-1:0]  mem [16];
    logic [3:0]             wptr, rptr;
    logic [4:0]             count;
    logic start_q, pend, tick, rise, fall, sample, keep, last, wend, full, do_wr, do_rd;

    assign tick       = dcnt >= div;
    assign rise       = tick && !clk;
    assign fall       = tick && clk;
    assign sample     = state == SHIFT && (READ_TRIG_SRC != 0 ? fall : rise);
    assign keep       = int'(scnt) >= READ_DELAY;
    assign last       = scnt == CNT_WIDTH'(N - 1);
    assign acc_n      = {acc, data_in};
    assign wend       = wbit == VW'(VALID_WIDTH - 1) || last;
    assign full       = count == 5'd16;
    assign do_wr      = pend && !full;
    assign do_rd      = fifo_rd_en && !fifo_empty;
    assign fifo_empty = count == 5'd0;
    assign fifo_q     = fifo_empty ? '0 : mem[rptr];
    assign clk_sr     = state == SHIFT && clk;

    // host staging register, shifted up 16 bits per write
    always_ff @(posedge clk_in) begin
        if (!rst)
            staging <= '0;
        else if (wr_en)
            staging <= {staging[COUNT_WIDTH-17:0], din};
    end

    // divider, sequencer FSM, serial output and readback accumulator
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            dcnt      <= '0;
            clk       <= 1'b0;
            sr        <= '0;
            data_out  <= 1'b0;
            load_sr   <= 1'b0;
            bcnt      <= '0;
            scnt      <= '0;
            wbit      <= '0;
            acc       <= '0;
            index     <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            start_q <= start;
            dcnt    <= tick ? '0 : dcnt + 1'b1;
            pend    <= 1'b0;
            if (tick)
                clk <= ~clk;
            case (state)
                IDLE: if (start && !start_q) begin
                    state    <= SHIFT;
                    dcnt     <= '0;
                    clk      <= 1'b0;
                    data_out <= SHIFT_DIRECTION != 0 ? staging[WIDTH-1] : staging[0];
                    sr       <= SHIFT_DIRECTION != 0 ? staging << (COUNT_WIDTH - WIDTH + 1) : (staging & MASK) >> 1;
                    bcnt     <= '0;
                    scnt     <= '0;
                    wbit     <= '0;
                    acc      <= '0;
                    index    <= '0;
                end
                SHIFT: begin
                    if (fall) begin
                        bcnt     <= bcnt + 1'b1;
                        data_out <= SHIFT_DIRECTION != 0 ? sr[COUNT_WIDTH-1] : sr[0];
                        sr       <= SHIFT_DIRECTION != 0 ? sr << 1 : sr >> 1;
                        if (bcnt == CNT_WIDTH'(N - 1)) begin
                            state    <= LOAD;
                            load_sr  <= 1'b1;
                            data_out <= 1'b0;
                        end
                    end
                    if (sample) begin
                        scnt <= scnt + 1'b1;
                        if (keep && wend) begin
                            pend      <= 1'b1;
                            pend_data <= {index, acc_n};
                            acc       <= '0;
                            wbit      <= '0;
                            index     <= index + 1'b1;
                        end else if (keep) begin
                            acc  <= acc_n[VALID_WIDTH-2:0];
                            wbit <= wbit + 1'b1;
                        end
                    end
                end
                LOAD: if (fall) begin
                    state   <= IDLE;
                    load_sr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since fifo_q is masked while empty
    always_ff @(posedge clk_in) begin
        if (do_wr)
            mem[wptr] <= pend_data;
    end

    // FIFO pointers, occupancy and optional overflow flag
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
`ifdef TOP_SR_FIFO_OVERFLOW_EN
            fifo_overflow <= 1'b0;
`endif
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
            count <= count + 5'(do_wr) - 5'(do_rd);
`ifdef TOP_SR_FIFO_OVERFLOW_EN
            if (pend && full)
                fifo_overflow <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_top_sr.sv
// tb_top_sr: directed vector-table bench for top_sr
module tb_top_sr;
    logic        clk_in = 0, rst = 0, start = 0, wr_en = 0, fifo_rd_en = 0;
    logic [15:0] din = 0;
    logic [5:0]  div = 0;
    logic        data_in;
    logic        clk_sr, data_out, load_sr, clk, fifo_empty;
    logic [35:0] fifo_q;
`ifdef TOP_SR_FIFO_OVERFLOW_EN
    logic        fifo_overflow;
`endif
    logic        dly = 0, loop = 0, dconst = 0;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [63:0] stage;
        logic [5:0]  div;
        logic        loop;
        logic        dconst;
        logic [35:0] exp0;
        logic [35:0] exp1;
    } vec_t;
    vec_t vecs[4];

    top_sr dut (
        .clk_in(clk_in), .rst(rst), .start(start), .wr_en(wr_en), .din(din),
        .data_in(data_in), .div(div), .fifo_rd_en(fifo_rd_en),
        .clk_sr(clk_sr), .data_out(data_out), .load_sr(load_sr), .clk(clk),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q)
`ifdef TOP_SR_FIFO_OVERFLOW_EN
        , .fifo_overflow(fifo_overflow)
`endif
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) dly <= data_out;
    assign data_in = loop ? dly : dconst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_stage(input logic [63:0] s);
        for (int i = 3; i >= 0; i--) begin
            wr_en = 1;
            din = s[i*16 +: 16];
            @(negedge clk_in);
        end
        wr_en = 0;
    endtask

    task automatic run_op(input vec_t v, input bit stress);
        int cyc, rises, first_rise, last_rise, load_start, load_len, per_err, dout_err, extra;
        logic [49:0] got;
        logic prev_clk_sr, prev_load, done;
        cyc = 0; rises = 0; first_rise = -1; last_rise = -1; load_start = -1;
        load_len = 0; per_err = 0; dout_err = 0; got = '0;
        prev_clk_sr = 0; prev_load = 0; done = 0;
        loop = v.loop; dconst = v.dconst; div = v.div;
        load_stage(v.stage);
        start = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
            if (stress) begin
                start = (cyc < 4) || (cyc >= 60 && cyc < 62);
                wr_en = cyc >= 30 && cyc < 34;
                din = 16'hFFFF;
            end else
                start = 0;
            if (clk_sr && !prev_clk_sr) begin
                if (rises == 0)
                    first_rise = cyc;
                else if (cyc - last_rise != 2 * (int'(v.div) + 1))
                    per_err++;
                last_rise = cyc;
                rises++;
                got = {got[48:0], data_out};
            end
            if (load_sr) begin
                if (load_len == 0)
                    load_start = cyc;
                load_len++;
                if (data_out)
                    dout_err++;
            end
            if (prev_load && !load_sr)
                done = 1;
            prev_clk_sr = clk_sr;
            prev_load = load_sr;
        end
        start = 0;
        wr_en = 0;
        chk("first_rise", first_rise, int'(v.div) + 2);
        chk("pulses", rises, 50);
        chk("period_errors", per_err, 0);
        chk("stream", got, v.stage[49:0]);
        chk("load_len", load_len, 2 * (int'(v.div) + 1));
        chk("load_start", load_start, last_rise + int'(v.div) + 1);
        chk("load_data_out", dout_err, 0);
        if (stress) begin
            extra = 0;
            repeat (100) begin
                @(negedge clk_in);
                if (clk_sr || load_sr)
                    extra++;
            end
            chk("single_op", extra, 0);
        end
    endtask

    task automatic check_fifo(input logic [35:0] e0, input logic [35:0] e1);
        chk("fifo_nonempty", fifo_empty, 0);
        chk("word0", fifo_q, e0);
        fifo_rd_en = 1;
        @(negedge clk_in);
        fifo_rd_en = 0;
        chk("word1", fifo_q, e1);
        fifo_rd_en = 1;
        @(negedge clk_in);
        fifo_rd_en = 0;
        chk("fifo_empty_after", fifo_empty, 1);
        chk("fifo_q_empty", fifo_q, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_clk_sr", clk_sr, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_load_sr", load_sr, 0);
        chk("rst_clk", clk, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_q", fifo_q, 0);
`ifdef TOP_SR_FIFO_OVERFLOW_EN
        chk("rst_overflow", fifo_overflow, 0);
`endif
    endtask

    initial begin
        int pops, werr;
        vecs[0] = '{64'h8423_8425_8427_8429, 6'd2, 1'b1, 1'b0, 36'h0_E1096109, 36'h1_00038429};
        vecs[1] = '{64'h8423_8425_8427_8429, 6'd2, 1'b0, 1'b0, 36'h0_00000000, 36'h1_00000000};
        vecs[2] = '{64'h5555_AAAA_0F0F_F0F0, 6'd0, 1'b0, 1'b1, 36'h0_FFFFFFFF, 36'h1_0003FFFF};
        vecs[3] = '{64'hDEAD_0001_8000_0001, 6'd1, 1'b1, 1'b0, 36'h0_40006000, 36'h1_00000001};

        rst = 0;
        repeat (10) @(negedge clk_in);
        check_reset_outputs();
        rst = 1;
        @(negedge clk_in);

        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i], 0);
            check_fifo(vecs[i].exp0, vecs[i].exp1);
        end

        run_op(vecs[0], 1);
        check_fifo(vecs[0].exp0, vecs[0].exp1);

        for (int i = 0; i < 9; i++)
            run_op(vecs[1], 0);
`ifdef TOP_SR_FIFO_OVERFLOW_EN
        chk("overflow_set", fifo_overflow, 1);
`endif
        pops = 0;
        werr = 0;
        while (!fifo_empty && pops < 40) begin
            if (fifo_q !== {3'b0, pops[0], 32'b0})
                werr++;
            fifo_rd_en = 1;
            @(negedge clk_in);
            fifo_rd_en = 0;
            pops++;
        end
        chk("stored_words", pops, 16);
        chk("stored_word_errors", werr, 0);

        run_op(vecs[0], 0);
        loop = 0;
        load_stage(vecs[0].stage);
        start = 1;
        @(negedge clk_in);
        start = 0;
        repeat (40) @(negedge clk_in);
        rst = 0;
        @(negedge clk_in);
        check_reset_outputs();
        rst = 1;
        @(negedge clk_in);

        run_op(vecs[3], 0);
        check_fifo(vecs[3].exp0, vecs[3].exp1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/top_sr.md
# top_sr

Serial shift-register configuration master with readback capture. Collects 16-bit host words into a staging register. On a start request it shifts WIDTH bits out serially on a divided clock, then pulses a load strobe. It samples the returned serial stream into 32-bit words queued in an internal FIFO for the host to read.

## Interface
- WIDTH, 50: serial bits per operation (≤ COUNT_WIDTH)
- CNT_WIDTH, 8: bit-counter width (must hold WIDTH+READ_DELAY)
- DIV_WIDTH, 6: divider setting width
- COUNT_WIDTH, 64: staging register width (multiple of 16)
- VALID_WIDTH, 32: readback data bits per FIFO word
- NUM_WIDTH, 4: word-index field width; FIFO_WIDTH = NUM_WIDTH+VALID_WIDTH
- FIFO_WIDTH, 36: FIFO word width
- SHIFT_DIRECTION, 1: 1 = MSB (bit WIDTH-1) first, 0 = LSB first
- READ_TRIG_SRC, 0: 0 = sample data_in on clk_sr rising edge, 1 = on falling edge
- READ_DELAY, 0: extra clk_sr pulses appended; the first READ_DELAY samples are discarded
- clk_in in 1: system clock
- rst in 1: synchronous, active-low reset
- start in 1: operation request, rising-edge detected
- wr_en in 1: push din into staging
- din in 16: staging data word
- data_in in 1: serial readback from the chain
- div in DIV_WIDTH: half-period of the divided clock = div+1 clk_in cycles
- fifo_rd_en in 1: pop FIFO head
- clk_sr out 1: gated shift clock
- data_out out 1: serial data
- load_sr out 1: load strobe
- clk out 1: free-running divided clock
- fifo_empty out 1: FIFO empty flag
- fifo_q out FIFO_WIDTH: FIFO head, first-word-fall-through

## Operation
- Staging: on wr_en, staging <= {staging[COUNT_WIDTH-17:0], din}. Shift data = staging[WIDTH-1:0], captured at operation start. Writes during an operation affect only later operations.
- Divider: counter 0..div. On reaching div it wraps and toggles clk. clk_sr mirrors clk only in SHIFT; otherwise it is 0.
- FSM IDLE→SHIFT→LOAD→IDLE.
  - IDLE: a start rising edge loads the shift register, clears the divider and clk, and enters SHIFT.
  - Start edges outside IDLE are ignored.
- SHIFT: produces N = WIDTH+READ_DELAY clk_sr pulses.
  - data_out updates while clk_sr is low: first bit at SHIFT entry, next bit at each clk_sr falling edge.
  - Bits after WIDTH are driven 0.
  - After the N-th falling edge, go to LOAD.
- LOAD: load_sr=1 for 2(div+1) cycles, data_out=0, then IDLE.
- Readback:
  - Skip the first READ_DELAY sample edges. Shift each following sample into acc <= {acc[VALID_WIDTH-2:0], data_in}.
  - Every VALID_WIDTH samples, and at the final sample, write {index, acc} and clear acc. A partial last word is right-aligned and zero-filled.
  - index restarts at 0 each operation and wraps mod 2^NUM_WIDTH.
- FIFO: depth 16. A write when full is dropped. fifo_rd_en when empty is ignored. A simultaneous read and write is legal.

## Timing
- Reset values: clk_sr 0, data_out 0, load_sr 0, clk 0, fifo_empty 1, fifo_q 0, FSM IDLE. Staging, accumulator and FIFO are cleared.
- rst low mid-operation aborts immediately to the reset state.
- Start is registered. A rising edge seen at cycle T puts the FSM in SHIFT at T+1. The first clk_sr rise is at T+1+(div+1).
- clk_sr period is 2(div+1) cycles. SHIFT lasts N·2(div+1) cycles.
- A FIFO write occurs 1 cycle after the completing sample edge. fifo_empty deasserts the cycle after the write.
- fifo_q is valid whenever fifo_empty=0. It advances the cycle after fifo_rd_en.

## Configuration
- TOP_SR_FIFO_OVERFLOW_EN defined: adds output fifo_overflow (1 bit). It is sticky, set when a write is dropped because the FIFO is full, and cleared only by reset.
- Undefined: no port; dropped writes are silent.

## Test plan
- Reset: rst low 10 cycles → all outputs at reset values, fifo_empty=1.
- Staging and MSB-first shift: write 0x8423, 0x8425, 0x8427, 0x8429, div=2, then start → 50 clk_sr pulses, 6-cycle period. data_out reproduces staging[49:0] MSB first: bits 0x0423_8425_8427_8429 truncated to 50 bits. load_sr high 6 cycles after SHIFT.
- Readback loop (data_in tied to data_out, delayed one clk_in) → two FIFO words: {0, bits 49..18}, {1, 18-bit remainder right-aligned}. Pop both, then fifo_empty=1.
- data_in=0 constant → two words 0x0_00000000 and 0x1_00000000.
- Start held 4 cycles, re-pulsed mid-SHIFT → exactly one operation; wr_en during SHIFT does not change the output stream.
- 9 operations without popping → 16 words stored, remaining 2 dropped; fifo_overflow=1 when TOP_SR_FIFO_OVERFLOW_EN is defined.
